// File: rtl/rf_issue_ctrl.sv
// rf_issue_ctrl: issue handshake between the decoder and the register file.
// Tracks ROB occupancy, stalls when the ROB is full, and sequences a
// fixed-length flush plus one recovery cycle after a ROB exception.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | accepting decoder instructions (dec_ready=1)
//   STALL   | ROB full, waiting for a commit to free an entry
//   FLUSH   | rf_flush held high while the flush counter runs down
//   RECOVER | single quiet cycle after the flush, then back to RUN
module rf_issue_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int FLUSH_LEN = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_valid,
    input  logic [4:0]                 dec_rd,
    input  logic [31:0]                dec_pc,
    input  logic                       rob_commit,
    input  logic                       rob_exception,
    output logic                       dec_ready,
    output logic                       rf_issue_empty,
    output logic [4:0]                 rf_rd,
    output logic [31:0]                rf_pc,
    output logic                       rf_flush,
    output logic [$clog2(ROB_DEPTH):0] inflight,
    output logic                       err_underflow
);

    localparam int IW = $clog2(ROB_DEPTH) + 1;
    localparam int CW = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        FLUSH   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] flush_cnt, flush_cnt_nxt;
    logic [IW-1:0] inflight_nxt;
    logic          err_nxt;
    logic          issue_q;
    logic          fire;
    logic          commit_ok;
    logic          commit_dec;

    assign rf_issue_empty = ~issue_q;

    // Next-state, occupancy and handshake decode; the exception overrides everything.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        inflight_nxt  = inflight;
        err_nxt       = err_underflow;
        dec_ready     = rst && (state == RUN) && !rob_exception;
        fire          = dec_valid && dec_ready;
        commit_ok     = rob_commit && ((state == RUN) || (state == STALL));
        commit_dec    = 1'b0;
        rf_flush      = (state == FLUSH);

        if (rob_exception) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = CW'(FLUSH_LEN);
            inflight_nxt  = '0;
        end else begin
            if (commit_ok && (inflight == '0)) begin
                err_nxt = 1'b1;
            end
            commit_dec = commit_ok && (inflight != '0);
            if (fire && !commit_dec) begin
                inflight_nxt = inflight + 1'b1;
            end else if (commit_dec && !fire) begin
                inflight_nxt = inflight - 1'b1;
            end

            case (state)
                RUN: begin
                    if (inflight_nxt == IW'(ROB_DEPTH)) begin
                        state_nxt = STALL;
                    end
                end
                STALL: begin
                    if (rob_commit) begin
                        state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    if (flush_cnt <= CW'(1)) begin
                        state_nxt     = RECOVER;
                        flush_cnt_nxt = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 1'b1;
                    end
                end
                RECOVER: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // Control state register: FSM, flush counter, occupancy, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            flush_cnt     <= '0;
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            state         <= state_nxt;
            flush_cnt     <= flush_cnt_nxt;
            inflight      <= inflight_nxt;
            err_underflow <= err_nxt;
        end
    end

    // Issue pipeline stage: capture the accepted instruction, hold it otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_q <= 1'b0;
            rf_rd   <= '0;
            rf_pc   <= '0;
        end else begin
            issue_q <= fire;
            if (fire) begin
                rf_rd <= dec_rd;
                rf_pc <= dec_pc;
            end
        end
    end

endmodule

// File: tb/tb_rf_issue_ctrl.sv
// Directed bench for rf_issue_ctrl with hand-computed expectations.
module tb_rf_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_rd;
    logic [31:0] dec_pc;
    logic        rob_commit;
    logic        rob_exception;
    logic        dec_ready;
    logic        rf_issue_empty;
    logic [4:0]  rf_rd;
    logic [31:0] rf_pc;
    logic        rf_flush;
    logic [4:0]  inflight;
    logic        err_underflow;

    int checks   = 0;
    int failures = 0;

    rf_issue_ctrl #(.ROB_DEPTH(16), .FLUSH_LEN(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_rd         (dec_rd),
        .dec_pc         (dec_pc),
        .rob_commit     (rob_commit),
        .rob_exception  (rob_exception),
        .dec_ready      (dec_ready),
        .rf_issue_empty (rf_issue_empty),
        .rf_rd          (rf_rd),
        .rf_pc          (rf_pc),
        .rf_flush       (rf_flush),
        .inflight       (inflight),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; dec_valid = 1'b0; dec_rd = '0; dec_pc = '0;
        rob_commit = 1'b0; rob_exception = 1'b0;
        #3;
        checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", dec_ready); end
        checks++; if (rf_issue_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", rf_issue_empty); end
        checks++; if (rf_rd !== 5'd0 || rf_pc !== 32'd0) begin failures++; $display("FAIL reset_rd_pc got=%0d/%h exp=0/0", rf_rd, rf_pc); end
        checks++; if (rf_flush !== 1'b0 || err_underflow !== 1'b0) begin failures++; $display("FAIL reset_flush_err got=%b/%b exp=0/0", rf_flush, err_underflow); end
        checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        repeat (2) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", dec_ready); end
        tick();
    endtask

    task automatic test_single_issue();
        dec_valid = 1'b1; dec_rd = 5'd5; dec_pc = 32'h100;
        tick();
        dec_valid = 1'b0; dec_rd = 5'd22; dec_pc = 32'hdead;
        checks++; if (rf_issue_empty !== 1'b0) begin failures++; $display("FAIL issue_empty got=%b exp=0", rf_issue_empty); end
        checks++; if (rf_rd !== 5'd5 || rf_pc !== 32'h100) begin failures++; $display("FAIL issue_rd_pc got=%0d/%h exp=5/100", rf_rd, rf_pc); end
        checks++; if (inflight !== 5'd1) begin failures++; $display("FAIL issue_inflight got=%0d exp=1", inflight); end
        tick();
        checks++; if (rf_issue_empty !== 1'b1 || rf_rd !== 5'd5 || rf_pc !== 32'h100) begin failures++; $display("FAIL issue_hold got=%b/%0d/%h exp=1/5/100", rf_issue_empty, rf_rd, rf_pc); end
        rob_commit = 1'b1;
        tick();
        rob_commit = 1'b0;
        checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL issue_drain got=%0d exp=0", inflight); end
    endtask

    task automatic test_back_to_back();
        dec_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dec_rd = 5'(i); dec_pc = 32'h200 + 32'(i);
            tick();
        end
        dec_rd = 5'd30; dec_pc = 32'hbad;
        checks++; if (inflight !== 5'd16) begin failures++; $display("FAIL b2b_full got=%0d exp=16", inflight); end
        checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready got=%b exp=0", dec_ready); end
        checks++; if (rf_rd !== 5'd15 || rf_pc !== 32'h20f) begin failures++; $display("FAIL b2b_last got=%0d/%h exp=15/20f", rf_rd, rf_pc); end
        tick();
        checks++; if (inflight !== 5'd16 || rf_issue_empty !== 1'b1) begin failures++; $display("FAIL b2b_no_issue got=%0d/%b exp=16/1", inflight, rf_issue_empty); end
        dec_valid = 1'b0; rob_commit = 1'b1;
        tick();
        rob_commit = 1'b0;
        checks++; if (inflight !== 5'd15) begin failures++; $display("FAIL b2b_commit got=%0d exp=15", inflight); end
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_again got=%b exp=1", dec_ready); end
        rob_commit = 1'b1;
        repeat (8) tick();
        rob_commit = 1'b0;
        checks++; if (inflight !== 5'd7) begin failures++; $display("FAIL b2b_drain got=%0d exp=7", inflight); end
    endtask

    task automatic test_fire_commit();
        dec_valid = 1'b1; rob_commit = 1'b1; dec_rd = 5'd7; dec_pc = 32'h300;
        tick();
        dec_valid = 1'b0; rob_commit = 1'b0;
        checks++; if (inflight !== 5'd7) begin failures++; $display("FAIL fire_commit_inflight got=%0d exp=7", inflight); end
        checks++; if (rf_issue_empty !== 1'b0 || rf_rd !== 5'd7) begin failures++; $display("FAIL fire_commit_issue got=%b/%0d exp=0/7", rf_issue_empty, rf_rd); end
        dec_valid = 1'b1; dec_rd = 5'd0; dec_pc = 32'h304;
        repeat (2) tick();
        dec_valid = 1'b0;
        checks++; if (inflight !== 5'd9 || rf_rd !== 5'd0 || rf_pc !== 32'h304) begin failures++; $display("FAIL x0_forward got=%0d/%0d/%h exp=9/0/304", inflight, rf_rd, rf_pc); end
    endtask

    task automatic test_exception();
        dec_valid = 1'b1; dec_rd = 5'd9; dec_pc = 32'h400; rob_exception = 1'b1;
        #1;
        checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL exc_ready_comb got=%b exp=0", dec_ready); end
        tick();
        rob_exception = 1'b0; dec_valid = 1'b0; rob_commit = 1'b1;
        checks++; if (inflight !== 5'd0 || rf_issue_empty !== 1'b1 || rf_rd !== 5'd0) begin failures++; $display("FAIL exc_no_issue got=%0d/%b/%0d exp=0/1/0", inflight, rf_issue_empty, rf_rd); end
        checks++; if (rf_flush !== 1'b1 || dec_ready !== 1'b0) begin failures++; $display("FAIL exc_flush1 got=%b/%b exp=1/0", rf_flush, dec_ready); end
        tick();
        checks++; if (rf_flush !== 1'b1) begin failures++; $display("FAIL exc_flush2 got=%b exp=1", rf_flush); end
        tick();
        rob_commit = 1'b0;
        checks++; if (rf_flush !== 1'b1 || err_underflow !== 1'b0 || inflight !== 5'd0) begin failures++; $display("FAIL exc_flush3 got=%b/%b/%0d exp=1/0/0", rf_flush, err_underflow, inflight); end
        tick();
        checks++; if (rf_flush !== 1'b0 || dec_ready !== 1'b0) begin failures++; $display("FAIL exc_recover got=%b/%b exp=0/0", rf_flush, dec_ready); end
        tick();
        checks++; if (dec_ready !== 1'b1 || rf_flush !== 1'b0) begin failures++; $display("FAIL exc_run got=%b/%b exp=1/0", dec_ready, rf_flush); end
    endtask

    task automatic test_double_exception();
        rob_exception = 1'b1;
        tick();
        rob_exception = 1'b0;
        tick();
        checks++; if (rf_flush !== 1'b1) begin failures++; $display("FAIL dbl_second_cycle got=%b exp=1", rf_flush); end
        rob_exception = 1'b1;
        tick();
        rob_exception = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rf_flush !== 1'b1) begin failures++; $display("FAIL dbl_restart_%0d got=%b exp=1", i, rf_flush); end
            tick();
        end
        checks++; if (rf_flush !== 1'b0 || dec_ready !== 1'b0) begin failures++; $display("FAIL dbl_recover got=%b/%b exp=0/0", rf_flush, dec_ready); end
        tick();
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL dbl_run got=%b exp=1", dec_ready); end
    endtask

    task automatic test_underflow_and_reset();
        rob_commit = 1'b1;
        tick();
        rob_commit = 1'b0;
        checks++; if (inflight !== 5'd0 || err_underflow !== 1'b1) begin failures++; $display("FAIL underflow got=%0d/%b exp=0/1", inflight, err_underflow); end
        repeat (3) tick();
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
        dec_valid = 1'b1; dec_rd = 5'd12; dec_pc = 32'h500;
        tick();
        dec_valid = 1'b0; rob_exception = 1'b1;
        tick();
        rob_exception = 1'b0;
        checks++; if (rf_flush !== 1'b1) begin failures++; $display("FAIL rst_pre_flush got=%b exp=1", rf_flush); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rf_flush !== 1'b0 || dec_ready !== 1'b0 || rf_issue_empty !== 1'b1) begin failures++; $display("FAIL rst_mid_flush_ctl got=%b/%b/%b exp=0/0/1", rf_flush, dec_ready, rf_issue_empty); end
        checks++; if (rf_rd !== 5'd0 || rf_pc !== 32'd0 || inflight !== 5'd0 || err_underflow !== 1'b0) begin failures++; $display("FAIL rst_mid_flush_data got=%0d/%h/%0d/%b exp=0/0/0/0", rf_rd, rf_pc, inflight, err_underflow); end
        @(negedge clk);
        @(posedge clk);
        #4 rst = 1'b1;
        #1;
        checks++; if (dec_ready !== 1'b1 || rf_flush !== 1'b0) begin failures++; $display("FAIL rst_release got=%b/%b exp=1/0", dec_ready, rf_flush); end
        tick();
        checks++; if (dec_ready !== 1'b1 || rf_flush !== 1'b0) begin failures++; $display("FAIL rst_no_recover got=%b/%b exp=1/0", dec_ready, rf_flush); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_fire_commit();
        test_exception();
        test_double_exception();
        test_underflow_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
